// File: rtl/shake_msg_packer.sv
// shake_msg_packer: packs a 64-bit word stream into 1088-bit SHAKE256 rate blocks
// for the absorb core, and emits the extra zero-length block that padding needs
// when a message ends exactly on a block boundary.
// Ports: clock/reset (async, active-low); s_data/s_valid/s_last/s_bytes/s_ready
// word input; full from the core; message/length/blk_valid/blk_last block output.
// Latency: last word accepted in cycle N -> blk_valid in N+1; s_ready and
// blk_valid come straight from flops, so there is no path from full or s_valid.
// Backpressure: s_ready drops while a block is held; full freezes the held block.
// Optional: define SHAKE_PACK_BSWAP_EN to byte-reverse each word before packing.
module shake_msg_packer #(
  parameter int WORD_W = 64,
  parameter int RATE   = 1088
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  input  logic [3:0]        s_bytes,
  output logic              s_ready,
  input  logic              full,
  output logic [RATE-1:0]   message,
  output logic [10:0]       length,
  output logic              blk_valid,
  output logic              blk_last
);

  localparam int WORDS = RATE / WORD_W;  // 17 words per block

  typedef enum logic [1:0] {FILL, HOLD, PADBLK} state_t;

  state_t            state;
  logic [4:0]        wcnt;
  logic              pad_pending;

  logic [3:0]        nbytes;
  logic [WORD_W-1:0] word_ord;
  logic [WORD_W-1:0] word_msk;
  logic [10:0]       new_len;
  logic [10:0]       slot_top;
  logic              is_top;
  logic              exact_fill;

  // Byte count of the incoming word: only the final word may be short, and
  // anything above 8 is clamped so length can never overshoot the rate.
  always_comb begin
    nbytes = 4'd8;
    if (s_last && (s_bytes < 4'd8)) nbytes = s_bytes;
  end

  // Byte ordering then masking: the first nbytes bytes (in packing order)
  // survive, the rest are zeroed.
  always_comb begin
    word_ord = s_data;
`ifdef SHAKE_PACK_BSWAP_EN
    for (int i = 0; i < 8; i++) word_ord[8*i +: 8] = s_data[WORD_W-8-8*i +: 8];
`endif
    word_msk = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes) word_msk[WORD_W-8-8*i +: 8] = word_ord[WORD_W-8-8*i +: 8];
    end
  end

  assign new_len    = length + {4'b0000, nbytes, 3'b000};
  assign slot_top   = 11'(RATE - 1) - {wcnt, 6'b000000};
  assign is_top     = (wcnt == 5'(WORDS - 1));
  // Final word lands exactly on the block boundary: padding needs a further
  // empty block, so this full block is not the last one.
  assign exact_fill = s_last && is_top && (new_len == 11'(RATE));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= FILL;
      wcnt        <= '0;
      pad_pending <= 1'b0;
      message     <= '0;
      length      <= '0;
      blk_valid   <= 1'b0;
      blk_last    <= 1'b0;
      s_ready     <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            message[slot_top -: WORD_W] <= word_msk;
            length <= new_len;
            wcnt   <= wcnt + 5'd1;
            if (s_last || is_top) begin
              state       <= HOLD;
              s_ready     <= 1'b0;
              blk_valid   <= 1'b1;
              blk_last    <= s_last && !exact_fill;
              pad_pending <= exact_fill;
            end
          end
        end
        HOLD: begin
          if (!full) begin
            wcnt    <= '0;
            message <= '0;
            length  <= '0;
            if (pad_pending) begin
              state       <= PADBLK;
              pad_pending <= 1'b0;
              blk_last    <= 1'b1;
            end else begin
              state     <= FILL;
              blk_valid <= 1'b0;
              blk_last  <= 1'b0;
              s_ready   <= 1'b1;
            end
          end
        end
        PADBLK: begin
          if (!full) begin
            state     <= FILL;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            s_ready   <= 1'b1;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shake_msg_packer.sv
`timescale 1ns/1ps
module tb_shake_msg_packer;
  localparam int RATE = 1088;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [63:0]     s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_last = 1'b0;
  logic [3:0]      s_bytes = '0;
  logic            s_ready;
  logic            full = 1'b0;
  logic [RATE-1:0] message;
  logic [10:0]     length;
  logic            blk_valid;
  logic            blk_last;

  shake_msg_packer dut (
    .clock(clock), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_bytes(s_bytes),
    .s_ready(s_ready), .full(full),
    .message(message), .length(length), .blk_valid(blk_valid), .blk_last(blk_last)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [RATE-1:0] msg;
    logic [10:0]     len;
    logic            last;
  } blk_t;

  blk_t       exp_q[$];
  logic [7:0] msg_bytes[$];
  int         checks = 0;
  int         errors = 0;
  bit         rand_full = 1'b0;
  bit         full_force = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic chk_msg(input string name, input logic [RATE-1:0] got, input logic [RATE-1:0] want);
    checks++;
    if (got !== want) begin
      int k;
      errors++;
      k = 0;
      while (k < 16 && got[RATE-1-64*k -: 64] === want[RATE-1-64*k -: 64]) k++;
      $display("FAIL %s: word %0d got %h want %h", name, k,
               got[RATE-1-64*k -: 64], want[RATE-1-64*k -: 64]);
    end
  endtask

  // Packing order of byte k within a word.
  function automatic logic [7:0] byte_of(input logic [63:0] w, input int k);
`ifdef SHAKE_PACK_BSWAP_EN
    return w[8*k +: 8];
`else
    return w[63-8*k -: 8];
`endif
  endfunction

  function automatic blk_t make_blk(input int pos, input int n);
    blk_t b;
    b.msg  = '0;
    for (int i = 0; i < n; i++) b.msg[RATE-1-8*i -: 8] = msg_bytes[pos+i];
    b.len  = 11'(8 * n);
    b.last = 1'b0;
    return b;
  endfunction

  // Reference: the message is a byte string; it splits into 136-byte blocks
  // that are never final, then one final block holding the remainder (which
  // is empty when the message length is a multiple of 136, including zero).
  task automatic model_push();
    int   total;
    int   pos;
    blk_t b;
    total = msg_bytes.size();
    pos   = 0;
    while (total - pos >= 136) begin
      b = make_blk(pos, 136);
      exp_q.push_back(b);
      pos += 136;
    end
    b = make_blk(pos, total - pos);
    b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  // Called at a negedge; returns at the negedge just after the word was taken.
  task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] b);
    int n;
    s_data = d; s_last = l; s_bytes = b; s_valid = 1'b1;
    n = 0;
    while (s_ready !== 1'b1) begin
      @(negedge clock);
      n++;
      if (n > 3000) begin
        $display("FAIL s_ready_timeout: got 0 want 1");
        $fatal(1, "stalled");
      end
    end
    @(negedge clock);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = {$urandom, $urandom};
    s_bytes = 4'($urandom_range(0, 15));
  endtask

  task automatic send_msg(input int nw, input int lb, input bit gaps,
                          input logic [63:0] w0, input bit use_w0);
    logic [63:0] words[$];
    int nb;
    msg_bytes.delete();
    for (int i = 0; i < nw; i++) begin
      logic [63:0] w;
      w = {$urandom, $urandom};
      if (i == 0 && use_w0) w = w0;
      words.push_back(w);
      nb = (i == nw - 1) ? ((lb > 8) ? 8 : lb) : 8;
      for (int k = 0; k < nb; k++) msg_bytes.push_back(byte_of(w, k));
    end
    model_push();
    for (int i = 0; i < nw; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
      send_word(words[i], (i == nw - 1),
                (i == nw - 1) ? 4'(lb) : 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Core-side backpressure.
  initial begin
    forever begin
      @(negedge clock);
      full = rand_full ? ($urandom_range(0, 2) == 0) : full_force;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks that a held
  // block stays frozen while the core is full.
  initial begin
    bit   held;
    blk_t prev;
    blk_t e;
    held = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", 64'(blk_valid), 64'd1);
          chk("hold_len", 64'(length), 64'(prev.len));
          chk("hold_last", 64'(blk_last), 64'(prev.last));
          chk_msg("hold_msg", message, prev.msg);
        end
        held = 1'b0;
        if (blk_valid) begin
          chk("ready_low_in_hold", 64'(s_ready), 64'd0);
          if (full) begin
            held      = 1'b1;
            prev.msg  = message;
            prev.len  = length;
            prev.last = blk_last;
          end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_block: got len %0d want none", length);
          end else begin
            e = exp_q.pop_front();
            chk("blk_len", 64'(length), 64'(e.len));
            chk("blk_last", 64'(blk_last), 64'(e.last));
            chk_msg("blk_msg", message, e.msg);
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] top_exp;
    logic [63:0] bsw_exp;
`ifdef SHAKE_PACK_BSWAP_EN
    top_exp = 64'h0000_0000_00EF_CDAB;
    bsw_exp = 64'hEFCD_AB89_6745_2301;
`else
    top_exp = 64'h0000_0000_0001_2345;
    bsw_exp = 64'h0123_4567_89AB_CDEF;
`endif
    // Reset state.
    repeat (3) @(negedge clock);
    chk("rst_message_zero", 64'(message == '0), 64'd1);
    chk("rst_length", 64'(length), 64'd0);
    chk("rst_blk_valid", 64'(blk_valid), 64'd0);
    chk("rst_blk_last", 64'(blk_last), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("ready_after_release", 64'(s_ready), 64'd1);

    // Single short word: latency and byte masking.
    send_msg(1, 3, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1);
    chk("lat_blk_valid", 64'(blk_valid), 64'd1);
    chk("one_len", 64'(length), 64'd24);
    chk("one_last", 64'(blk_last), 64'd1);
    chk("one_top_bytes", 64'(message[RATE-1 -: 24]), top_exp);
    @(negedge clock);
    chk("ready_n_plus_2", 64'(s_ready), 64'd1);
    chk("valid_clear_n_plus_2", 64'(blk_valid), 64'd0);

    // Boundary lengths, empty message, clamped byte count.
    send_msg(17, 8, 1'b0, 64'd0, 1'b0);
    drain("drain_17_words");
    send_msg(20, 8, 1'b1, 64'd0, 1'b0);
    drain("drain_20_words");
    send_msg(1, 0, 1'b0, 64'd0, 1'b0);
    send_msg(3, 12, 1'b1, 64'd0, 1'b0);
    send_msg(17, 0, 1'b0, 64'd0, 1'b0);
    send_msg(18, 0, 1'b0, 64'd0, 1'b0);
    drain("drain_edges");

    // Full word ordering.
    send_msg(1, 8, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1);
    chk("word0_order", message[RATE-1 -: 64], bsw_exp);
    drain("drain_order");

    // Core full for several cycles while a block is held.
    full_force = 1'b1;
    @(negedge clock);
    send_msg(2, 5, 1'b0, 64'd0, 1'b0);
    repeat (5) @(negedge clock);
    chk("full_still_valid", 64'(blk_valid), 64'd1);
    chk("full_ready_low", 64'(s_ready), 64'd0);
    full_force = 1'b0;
    repeat (3) @(negedge clock);
    chk("full_released", 64'(blk_valid), 64'd0);
    drain("drain_full");

    // Reset in the middle of a block discards it.
    for (int i = 0; i < 9; i++) send_word({$urandom, $urandom}, 1'b0, 4'd8);
    reset = 1'b0;
    #1;
    chk("midrst_message_zero", 64'(message == '0), 64'd1);
    chk("midrst_length", 64'(length), 64'd0);
    chk("midrst_blk_valid", 64'(blk_valid), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    send_msg(1, 8, 1'b0, 64'd0, 1'b0);
    chk("post_rst_len", 64'(length), 64'd64);
    drain("drain_post_rst");

    // Randomized messages with random backpressure and source gaps.
    rand_full = 1'b1;
    for (int m = 0; m < 30; m++) begin
      send_msg($urandom_range(1, 40), $urandom_range(0, 10), 1'b1, 64'd0, 1'b0);
    end
    drain("drain_random");
    rand_full = 1'b0;
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
